pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_hazard_ctrl_md_wait_counter.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard sequencer: memory access types (same as the bypass network),
// sequencer states, the pipeline control bundle and the load-use compare.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_ACCESS_TYPE_R2R = 2'd0,
        MEM_ACCESS_TYPE_R2M = 2'd1,
        MEM_ACCESS_TYPE_M2R = 2'd2
    } mem_access_type_e;

    typedef enum logic [1:0] {
        HAZ_S_RUN   = 2'd0,
        HAZ_S_MD    = 2'd1,
        HAZ_S_FLUSH = 2'd2
    } haz_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mm;
        logic bubble_id_ex;
        logic flush;
    } pipe_ctrl_t;

    // $0 is hard-wired, so a load targeting it can never create a dependency.
    function automatic logic load_use_hit(
        input logic [1:0]            ex_access_type,
        input logic [REG_ADDR_W-1:0] ex_dest_addr,
        input logic [REG_ADDR_W-1:0] id_rs_addr,
        input logic                  id_rs_read,
        input logic [REG_ADDR_W-1:0] id_rt_addr,
        input logic                  id_rt_read
    );
        return (ex_access_type == MEM_ACCESS_TYPE_M2R) && (ex_dest_addr != '0) &&
               ((id_rs_read && (id_rs_addr == ex_dest_addr)) ||
                (id_rt_read && (id_rt_addr == ex_dest_addr)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_wait_counter.sv
// MUL/DIV occupancy down-counter: loaded with LAT-1 on start, counts down while the sequencer
// sits in the MD state, and flags completion when it reaches zero.
module pipeline_hazard_ctrl_md_wait_counter #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 34,
    parameter int MD_CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_div,
    input  logic active,
    input  logic abort,
    output logic cnt_busy,
    output logic cnt_done
);

    localparam logic [MD_CNT_W-1:0] MUL_INIT = MD_CNT_W'(MUL_LAT - 1);
    localparam logic [MD_CNT_W-1:0] DIV_INIT = MD_CNT_W'(DIV_LAT - 1);

    logic [MD_CNT_W-1:0] md_cnt;
    logic                md_zero;

    assign md_zero = (md_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= load_div ? DIV_INIT : MUL_INIT;
        end else if (active && !md_zero) begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
        end
    end

    assign cnt_busy = active && !md_zero;
    assign cnt_done = active && md_zero && !abort;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, MUL/DIV occupancy,
// memory wait and exception flush, resolved by a fixed priority.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 34,
    parameter int MD_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic                  id_rs_read,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rt_read,
    input  logic [REG_ADDR_W-1:0] ex_dest_addr,
    input  logic [1:0]            ex_access_type,
    input  logic                  ex_md_start,
    input  logic                  ex_md_is_div,
    input  logic                  mm_mem_busy,
    input  logic                  exc_req,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mm,
    output logic                  bubble_id_ex,
    output logic                  flush,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [PERF_W-1:0]     stall_cycles
);

    haz_state_e        state;
    pipe_ctrl_t        ctrl;
    logic              md_busy_c;
    logic              md_start_take;
    logic              md_cnt_busy;
    logic              md_cnt_done;
    logic              md_occupy;
    logic              lu_hit;
    logic [PERF_W-1:0] perf_cnt;

    // A start seen while memory is busy is not taken; EX keeps presenting it until accepted.
    assign md_start_take = (state == HAZ_S_RUN) && ex_md_start && !mm_mem_busy && !exc_req;
    assign md_occupy     = ((state == HAZ_S_RUN) && ex_md_start) || md_cnt_busy;
    assign lu_hit        = load_use_hit(ex_access_type, ex_dest_addr,
                                        id_rs_addr, id_rs_read, id_rt_addr, id_rt_read);

    pipeline_hazard_ctrl_md_wait_counter #(
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT),
        .MD_CNT_W (MD_CNT_W)
    ) u_md_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (md_start_take),
        .load_div (ex_md_is_div),
        .active   (state == HAZ_S_MD),
        .abort    (exc_req),
        .cnt_busy (md_cnt_busy),
        .cnt_done (md_cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HAZ_S_RUN;
        end else if (exc_req) begin
            state <= HAZ_S_FLUSH;
        end else begin
            case (state)
                HAZ_S_RUN:   if (md_start_take) state <= HAZ_S_MD;
                HAZ_S_MD:    if (!md_cnt_busy) state <= HAZ_S_RUN;
                HAZ_S_FLUSH: state <= HAZ_S_RUN;
                default:     state <= HAZ_S_RUN;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    always_comb begin
        ctrl      = '0;
        md_busy_c = 1'b0;
        if (rst) begin
            ctrl = '0;
        end else if (state == HAZ_S_FLUSH) begin
            ctrl.flush = 1'b1;
        end else begin
            md_busy_c = md_occupy;
            if (mm_mem_busy) begin
                ctrl.stall_pc    = 1'b1;
                ctrl.stall_if_id = 1'b1;
                ctrl.stall_id_ex = 1'b1;
                ctrl.stall_ex_mm = 1'b1;
            end else if (md_occupy) begin
                ctrl.stall_pc    = 1'b1;
                ctrl.stall_if_id = 1'b1;
                ctrl.stall_id_ex = 1'b1;
            end else if (lu_hit) begin
                ctrl.stall_pc     = 1'b1;
                ctrl.stall_if_id  = 1'b1;
                ctrl.bubble_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (ctrl.stall_pc && (perf_cnt != {PERF_W{1'b1}})) begin
            perf_cnt <= perf_cnt + PERF_W'(1);
        end
    end

    assign stall_pc     = ctrl.stall_pc;
    assign stall_if_id  = ctrl.stall_if_id;
    assign stall_id_ex  = ctrl.stall_id_ex;
    assign stall_ex_mm  = ctrl.stall_ex_mm;
    assign bubble_id_ex = ctrl.bubble_id_ex;
    assign flush        = ctrl.flush;
    assign md_busy      = md_busy_c;
    assign md_done      = !rst && md_cnt_done;
    assign stall_cycles = rst ? '0 : perf_cnt;

endmodule
